// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester handshake plus register-file write port.
// The slave side is the arbiter; the master side is the writeback sources and the register file.
interface regfile_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int AW      = 5,
   parameter int DW      = 32
);
   localparam int IW = $clog2(NUM_REQ);
   logic                  HOLD;
   logic [NUM_REQ-1:0]    REQ_VALID;
   logic [NUM_REQ-1:0]    REQ_READY;
   logic [NUM_REQ*AW-1:0] REQ_ADDR;
   logic [NUM_REQ*DW-1:0] REQ_DATA;
   logic                  WE3;
   logic [AW-1:0]         A3;
   logic [DW-1:0]         WD3;
   logic [IW-1:0]         GNT_IDX;
   logic                  BUSY;
   modport master (output HOLD, REQ_VALID, REQ_ADDR, REQ_DATA,
                   input REQ_READY, WE3, A3, WD3, GNT_IDX, BUSY);
   modport slave (input HOLD, REQ_VALID, REQ_ADDR, REQ_DATA,
                  output REQ_READY, WE3, A3, WD3, GNT_IDX, BUSY);
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port between writeback sources.
// Define RFWB_FIXED_PRIO_EN for fixed priority (lowest valid index wins, pointer held at 0).
module regfile_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int AW      = 5,
   parameter int DW      = 32,
   parameter int DROP_X0 = 1
) (
   input logic CLK,
   input logic RST,
   regfile_wb_arbiter_if.slave bus
);
   localparam int IW = $clog2(NUM_REQ);
   logic [IW-1:0] ptr, ptr_nxt, gnt, idx;
   logic          found, acc;
   logic [AW-1:0] addr;
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = IW'((int'(ptr) + k) % NUM_REQ);
         if (!found && bus.REQ_VALID[idx]) begin
            gnt   = idx;
            found = 1'b1;
         end
      end
   end
   assign acc           = found && !bus.HOLD && !RST;
   assign bus.REQ_READY = acc ? NUM_REQ'(1) << gnt : '0;
   assign bus.BUSY      = |(bus.REQ_VALID & ~bus.REQ_READY);
   assign addr          = bus.REQ_ADDR[gnt*AW +: AW];
`ifdef RFWB_FIXED_PRIO_EN
   assign ptr_nxt = '0;
`else
   assign ptr_nxt = (gnt == IW'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
`endif
   // Writes to x0 are still accepted and consume a grant; only the enable is suppressed.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr         <= '0;
         bus.WE3     <= 1'b0;
         bus.A3      <= '0;
         bus.WD3     <= '0;
         bus.GNT_IDX <= '0;
      end else begin
         bus.WE3 <= acc && !(DROP_X0 != 0 && addr == '0);
         if (acc) begin
            bus.A3      <= addr;
            bus.WD3     <= bus.REQ_DATA[gnt*DW +: DW];
            bus.GNT_IDX <= gnt;
            ptr         <= ptr_nxt;
         end
      end
   end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed vectors; expected writes are queued at grant time
// and matched by a monitor against every cycle the register file sees WE3.
module tb_regfile_wb_arbiter;
   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;
   typedef struct packed {logic [4:0] a; logic [31:0] d; logic [1:0] g;} exp_t;
   exp_t        exp_q[$];
   exp_t        e;
   logic [4:0]  addr [3];
   logic [31:0] data [3];

   regfile_wb_arbiter_if #(.NUM_REQ(3), .AW(5), .DW(32)) bus ();
   regfile_wb_arbiter #(.NUM_REQ(3), .AW(5), .DW(32), .DROP_X0(1)) dut (
      .CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic drive(input logic h, input logic [2:0] v);
      bus.HOLD      = h;
      bus.REQ_VALID = v;
      bus.REQ_ADDR  = {addr[2], addr[1], addr[0]};
      bus.REQ_DATA  = {data[2], data[1], data[0]};
   endtask

   // Drive one cycle, check the combinational grant, queue the write it should cause.
   task automatic step(input logic h, input logic [2:0] v, input logic [2:0] er, input logic eb);
      drive(h, v);
      #2;
      check("ready", 64'(bus.REQ_READY), 64'(er));
      check("busy", 64'(bus.BUSY), 64'(eb));
      for (int i = 0; i < 3; i++)
         if (er[i] && addr[i] != 5'd0) exp_q.push_back('{a: addr[i], d: data[i], g: 2'(i)});
      @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      if (bus.WE3 !== 1'b0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write got a3=%0d wd3=%h gnt=%0d want no write at %0t",
                     bus.A3, bus.WD3, bus.GNT_IDX, $time);
         end else begin
            e = exp_q.pop_front();
            check("write", 64'({bus.A3, bus.WD3, bus.GNT_IDX}), 64'(e));
         end
      end
   end

   initial begin
      RST = 1'b1;
      addr[0] = 5'd10; data[0] = 32'h0000_00A0;
      addr[1] = 5'd11; data[1] = 32'h0000_00A1;
      addr[2] = 5'd12; data[2] = 32'h0000_00A2;
      drive(1'b0, 3'b111);
      @(posedge CLK);
      #1;
      step(1'b0, 3'b111, 3'b000, 1'b1);
      check("rst_ready", 64'(bus.REQ_READY), 64'd0);
      check("rst_we3", 64'(bus.WE3), 64'd0);
      check("rst_a3", 64'(bus.A3), 64'd0);
      check("rst_wd3", 64'(bus.WD3), 64'd0);
      check("rst_gnt", 64'(bus.GNT_IDX), 64'd0);
      RST = 1'b0;
      step(1'b0, 3'b111, 3'b001, 1'b1);
      // single request from requester 1
      addr[1] = 5'd5; data[1] = 32'hDEAD_BEEF;
      step(1'b0, 3'b010, 3'b010, 1'b0);
      // x0 write from requester 2 is accepted but never enabled
      addr[2] = 5'd0; data[2] = 32'h0000_1234;
      step(1'b0, 3'b100, 3'b100, 1'b0);
      check("x0_we3", 64'(bus.WE3), 64'd0);
      check("x0_wd3", 64'(bus.WD3), 64'h1234);
      // round robin from pointer 0
      addr[1] = 5'd11; data[1] = 32'h0000_00A1;
      addr[2] = 5'd12; data[2] = 32'h0000_00A2;
      repeat (2) begin
         step(1'b0, 3'b111, 3'b001, 1'b1);
         step(1'b0, 3'b111, 3'b010, 1'b1);
         step(1'b0, 3'b111, 3'b100, 1'b1);
      end
      // hold freezes grants and pointer
      repeat (3) step(1'b1, 3'b101, 3'b000, 1'b1);
      check("hold_we3", 64'(bus.WE3), 64'd0);
      step(1'b0, 3'b101, 3'b001, 1'b1);
      step(1'b0, 3'b101, 3'b100, 1'b1);
      // reset arriving at the acceptance edge discards the write
      addr[0] = 5'd7; data[0] = 32'h0000_0077;
      drive(1'b0, 3'b001);
      #2;
      check("midrst_ready", 64'(bus.REQ_READY), 64'b001);
      RST = 1'b1;
      @(posedge CLK);
      #1;
      check("midrst_we3", 64'(bus.WE3), 64'd0);
      check("midrst_a3", 64'(bus.A3), 64'd0);
      drive(1'b0, 3'b000);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      // same-address writes land in grant order
      addr[0] = 5'd9; data[0] = 32'h0000_0001;
      addr[1] = 5'd9; data[1] = 32'h0000_0002;
      step(1'b0, 3'b011, 3'b001, 1'b1);
      step(1'b0, 3'b010, 3'b010, 1'b0);
      repeat (3) step(1'b0, 3'b000, 3'b000, 1'b0);
      check("pending_writes", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
